// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF stage: PC, req/ack fetch, skid buffer, redirect squash, HALT stop; optional counters under IF_PERF_CNT_EN
module inst_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b010001,
    parameter logic [31:0] NOP_INST    = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_2_id,
    output logic [31:0] pc4_in_2_id,
    output logic        halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] drain_tgt;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc4;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;
    logic        load_nop;
    logic        load_fetch;
    logic        load_skid;
    logic [31:0] load_inst;
    logic        load_halt;

    // Request is gated by the reset pin so an outstanding fetch is abandoned the moment reset asserts
    always_comb begin
        imem_req  = reset && ((state == S_FETCH) || (state == S_DRAIN));
        imem_addr = pc;
        halted    = (state == S_HALT);
    end

    // Decide what the output register takes this cycle; redirect outranks everything including stall
    always_comb begin
        pc_plus4     = pc + 32'd4;
        redirect_tgt = {redirect_pc[31:2], 2'b00};
        load_fetch   = (state == S_FETCH) && imem_ack && !stall_in && !redirect_valid;
        load_skid    = (state == S_HOLD) && !stall_in && !redirect_valid;
        load_nop     = redirect_valid
                     || ((state == S_FETCH) && !imem_ack && !stall_in)
                     || ((state == S_DRAIN) && !stall_in);
        load_inst    = load_fetch ? imem_rdata : skid_inst;
        load_halt    = (load_fetch || load_skid) && (load_inst[31:26] == HALT_OPCODE);
    end

    // Output register seen by ID: bubble, fresh fetch, or the skid entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_2_id   <= NOP_INST;
            pc4_in_2_id <= 32'd0;
        end else if (load_nop) begin
            inst_2_id   <= NOP_INST;
        end else if (load_fetch) begin
            inst_2_id   <= imem_rdata;
            pc4_in_2_id <= pc_plus4;
        end else if (load_skid) begin
            inst_2_id   <= skid_inst;
            pc4_in_2_id <= skid_pc4;
        end
    end

    // Fetch FSM: pc is always the address on the bus, so a draining request keeps its old address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            pc        <= {RESET_PC[31:2], 2'b00};
            drain_tgt <= 32'd0;
            skid_inst <= NOP_INST;
            skid_pc4  <= 32'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (redirect_valid) begin
                        if (imem_ack) begin
                            pc <= redirect_tgt;
                        end else begin
                            drain_tgt <= redirect_tgt;
                            state     <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc <= pc_plus4;
                        if (stall_in) begin
                            skid_inst <= imem_rdata;
                            skid_pc4  <= pc_plus4;
                            state     <= S_HOLD;
                        end else if (load_halt) begin
                            state <= S_HALT;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_tgt;
                        state <= S_FETCH;
                    end else if (!stall_in) begin
                        state <= load_halt ? S_HALT : S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        pc    <= redirect_valid ? redirect_tgt : drain_tgt;
                        state <= S_FETCH;
                    end else if (redirect_valid) begin
                        drain_tgt <= redirect_tgt;
                    end
                end
                S_HALT: begin
                    if (redirect_valid) begin
                        pc    <= redirect_tgt;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    // Count accepted non-squashed responses and cycles where a bubble enters the output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt  <= 32'd0;
            perf_bubble_cnt <= 32'd0;
        end else begin
            if ((state == S_FETCH) && imem_ack && !redirect_valid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (load_nop) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with directed and randomized stimulus
module tb_inst_fetch;

    localparam logic [31:0] NOP    = 32'hFC00_0000;
    localparam logic [31:0] HALT_W = 32'h4400_0000;
    localparam logic [5:0]  HALT_OP = 6'b010001;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst_2_id;
    logic [31:0] pc4_in_2_id;
    logic        halted;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    inst_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_2_id      (inst_2_id),
        .pc4_in_2_id    (pc4_in_2_id),
        .halted         (halted)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        req;
        logic [31:0] addr;
        logic        halt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: what ID sees, the next live fetch address, one buffered word,
    // a pending stale response to discard, and the halted flag
    logic [31:0] m_pc, m_inst, m_pc4, m_skid_inst, m_skid_pc4, m_stale_addr;
    logic        m_skid_full, m_stale, m_halt;
    logic [25:0] seq;

    task automatic model_init();
        m_pc = RST_PC; m_inst = NOP; m_pc4 = 32'd0;
        m_skid_full = 1'b0; m_skid_inst = 32'd0; m_skid_pc4 = 32'd0;
        m_stale = 1'b0; m_stale_addr = 32'd0; m_halt = 1'b0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.inst = m_inst;
        e.pc4  = m_pc4;
        e.req  = !m_skid_full && !m_halt;
        e.addr = m_stale ? m_stale_addr : m_pc;
        e.halt = m_halt;
        exp_q.push_back(e);
    endtask

    task automatic deliver(input logic [31:0] w, input logic [31:0] p4);
        m_inst = w;
        m_pc4  = p4;
        if (w[31:26] == HALT_OP) m_halt = 1'b1;
    endtask

    task automatic model_edge();
        logic        req;
        logic        acc;
        logic [31:0] tgt;
        if (!reset) begin
            model_init();
        end else begin
            req = !m_skid_full && !m_halt;
            acc = req && imem_ack;
            tgt = {redirect_pc[31:2], 2'b00};
            if (redirect_valid) begin
                m_inst = NOP; m_skid_full = 1'b0; m_halt = 1'b0;
                if (acc) m_stale = 1'b0;
                else if (req && !m_stale) begin
                    m_stale = 1'b1;
                    m_stale_addr = m_pc;
                end
                m_pc = tgt;
            end else if (m_stale) begin
                if (acc) m_stale = 1'b0;
                if (!stall_in) m_inst = NOP;
            end else if (m_skid_full) begin
                if (!stall_in) begin
                    deliver(m_skid_inst, m_skid_pc4);
                    m_skid_full = 1'b0;
                end
            end else if (!m_halt) begin
                if (acc) begin
                    if (stall_in) begin
                        m_skid_full = 1'b1;
                        m_skid_inst = imem_rdata;
                        m_skid_pc4  = m_pc + 32'd4;
                    end else begin
                        deliver(imem_rdata, m_pc + 32'd4);
                    end
                    m_pc = m_pc + 32'd4;
                end else if (!stall_in) begin
                    m_inst = NOP;
                end
            end
            push_exp();
        end
    endtask

    task automatic step(input logic a, input logic s, input logic r, input logic [31:0] rp, input logic h);
        imem_ack       = a;
        stall_in       = s;
        redirect_valid = r;
        redirect_pc    = rp;
        seq            = seq + 26'd1;
        imem_rdata     = h ? HALT_W : {6'b001000, seq};
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: reset state while reset is low, otherwise pop one expected record per cycle
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            checks++;
            if (imem_req !== 1'b0 || inst_2_id !== NOP || pc4_in_2_id !== 32'd0 || halted !== 1'b0) begin
                errors++;
                $display("FAIL reset_state t=%0t req=%b inst=%h pc4=%h halted=%b required req=0 inst=%h pc4=0 halted=0",
                         $time, imem_req, inst_2_id, pc4_in_2_id, halted, NOP);
            end
        end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (inst_2_id !== mon_e.inst || pc4_in_2_id !== mon_e.pc4 || imem_req !== mon_e.req ||
                halted !== mon_e.halt || (mon_e.req && imem_addr !== mon_e.addr)) begin
                errors++;
                $display("FAIL cycle_check t=%0t inst=%h/%h pc4=%h/%h req=%b/%b addr=%h/%h halted=%b/%b (actual/required)",
                         $time, inst_2_id, mon_e.inst, pc4_in_2_id, mon_e.pc4, imem_req, mon_e.req,
                         imem_addr, mon_e.addr, halted, mon_e.halt);
            end
        end
    end

    initial begin
        reset = 1'b0; imem_ack = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; imem_rdata = 32'd0; seq = 26'd0;
        model_init();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        push_exp();

        // zero-wait streaming
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        // wait states then ack
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        // stall with buffered data, then release
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        // redirect while a request is outstanding; low target bits must be dropped
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0043, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        // second redirect during drain replaces the target
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        // HALT, idle with ignored acks, then redirect out of it
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) step(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        // PC wrap at the top of the address space
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFB, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        // reset while a request is pending and a word is held on the outputs
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        reset = 1'b1;
        push_exp();
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 65),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom,
                 ($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch (IF) stage of the 5-stage pipeline. Keeps the PC and fetches instructions over a req/ack instruction-memory port.
- Delivers the registered instruction and PC+4 pair that the decode (ID) stage consumes.
- Handles ID back-pressure with a one-entry skid buffer, squashes wrong-path fetches on an EX branch redirect, and stops fetching at HALT.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- HALT_OPCODE, 6'b010001, opcode (inst[31:26]) that stops fetching.
- NOP_INST, 32'hFC00_0000, bubble instruction (opcode 6'b111111). Decodes to all-zero control.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address. Word-aligned; bits[1:0] always 0.
- imem_ack  in  1  request accepted; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- stall_in  in  1  ID cannot accept a new instruction; hold outputs.
- redirect_valid  in  1  taken branch/JR from EX; flush.
- redirect_pc  in  32  redirect target. bits[1:0] ignored (forced 0).
- inst_2_id  out  32  instruction to ID (registered).
- pc4_in_2_id  out  32  PC+4 of inst_2_id (registered).
- halted  out  1  HALT delivered; fetch stopped.

Behaviour:
- Reset (reset==0, async):
  - pc=RESET_PC; imem_req=0; inst_2_id=NOP_INST; pc4_in_2_id=0; halted=0.
  - Skid buffer empty; drop flag clear; FSM=S_FETCH.
  - The first request asserts in the first cycle after reset deasserts.
- Handshake:
  - imem_req and imem_addr stay stable until imem_ack is sampled high.
  - An ack may arrive in the same cycle as req (zero-wait). imem_ack when imem_req==0 is ignored.
  - Zero-wait throughput: 1 instruction/cycle. An instruction acked in cycle N appears on inst_2_id in cycle N+1.
- FSM states:
  - S_FETCH: req=1, addr=pc.
    - On ack with no stall and no redirect: capture rdata to the output register; pc4_in_2_id = pc+4; pc += 4; stay in S_FETCH.
    - No ack and not stalled: output register loads NOP_INST; pc4_in_2_id holds.
  - S_HOLD (entered on ack while stall_in=1): rdata and pc+4 go to the skid buffer; req=0; outputs hold.
    - When stall_in drops, the buffer moves to the output register and the FSM returns to S_FETCH.
    - The next request issues in that same cycle.
  - S_DRAIN (redirect while a request is unacked): req stays 1 at the old address; the response is discarded on ack.
    - The next cycle requests the saved redirect target.
  - S_HALT: entered when an instruction with opcode==HALT_OPCODE is loaded into the output register.
    - req=0; halted=1 from the next cycle; outputs hold the HALT instruction.
- Redirect rules:
  - Highest priority, above stall.
  - Output register <= NOP_INST; skid buffer cleared; pc <= {redirect_pc[31:2],2'b00}.
  - Ack in the same cycle as a redirect: that data is discarded.
  - Redirect while no request is outstanding: the new address is requested the next cycle.
  - Redirect in S_HALT: clears halted and resumes fetch at the target. An older branch resolves after HALT is fetched.
  - Redirect in S_DRAIN: replaces the saved target; the latest redirect wins.
- Stall:
  - While stall_in=1, inst_2_id and pc4_in_2_id hold their values.
  - At most one fetched instruction is buffered; req stays 0 while the buffer is full.
- PC arithmetic: modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0; pc4 wraps the same way.
- Reset mid-request: the outstanding request is abandoned and req drops immediately (async). Memory must tolerate this.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0], both reset to 0, wrap at 2^32.
  - perf_fetch_cnt: +1 per non-squashed ack.
  - perf_bubble_cnt: +1 per cycle NOP_INST is loaded into the output register (wait, flush).
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Zero-wait streaming: ack every cycle, rdata=32'h0420_0001.. → imem_addr 0,4,8,12 on consecutive cycles; pc4_in_2_id 4,8,12 one cycle after each ack.
- Wait states: ack 3 cycles after req at addr 0 → imem_addr held 0 for 3 cycles; inst_2_id=NOP_INST until cycle after ack, then rdata, pc4=4.
- Stall with buffered data: stall_in=1 for 4 cycles while ack for addr 8 arrives → outputs hold; req=0 after capture; on release, addr-8 instruction appears with pc4=12, and req for addr 12 in the same cycle.
- Redirect during an outstanding request: req at 0x10 unacked, redirect_valid with redirect_pc=0x40 → inst_2_id=NOP_INST; 0x10 data discarded on its ack; next req addr=0x40.
- HALT then redirect: fetch 32'h4400_0000 → halted=1, req=0 for 10 cycles; redirect_pc=0x80 → halted=0, req addr=0x80.
- Reset mid-wait: reset low while req pending → req=0, inst_2_id=NOP_INST asynchronously; after release the first req addr=RESET_PC.
